floo_hbm_rw_scheduler: RTL
==========================

# floo_hbm_rw_scheduler

Read/write phase scheduler on the joined AXI bus in front of an HBM channel, between the narrow/wide join output and the HBM channel model or controller. It groups AR and AW grants into phases of bounded length. It inserts a programmable turnaround gap between phases and caps outstanding reads and writes. The block adds no register stage: gating is combinational, and decisions are based on registered state.

## Interface
- MaxReadTxns, 8: maximum outstanding read transactions (AR accepted, R last not yet returned).
- MaxWriteTxns, 8: maximum outstanding write transactions (AW accepted, B not yet returned).
- PhaseBudget, 4: number of address handshakes per phase before yielding to the other direction; must be ≥1.
- TurnCycles, 2: number of idle address cycles when switching direction; 0 means direct switch.
- axi_req_t, logic: joined AXI request struct type.
- axi_rsp_t, logic: joined AXI response struct type.
- clk_i  in  1  clock; the only clock.
- rst_ni  in  1  asynchronous active-low reset.
- slv_req_i  in  axi_req_t  request from the join.
- slv_rsp_o  out  axi_rsp_t  response to the join.
- mst_req_o  out  axi_req_t  request to the HBM channel.
- mst_rsp_i  in  axi_rsp_t  response from the HBM channel.
- phase_o  out  2  current state: 0 = IDLE, 1 = READ, 2 = WRITE, 3 = TURN.
- rd_outstanding_o  out  $clog2(MaxReadTxns+1)  outstanding read count.
- wr_outstanding_o  out  $clog2(MaxWriteTxns+1)  outstanding write count.

## Operation
- All fields pass through unchanged except aw_valid/aw_ready and ar_valid/ar_ready, which are gated.
- W, B and R are never gated.
- ar_grant = (state==READ) && rd_cnt < MaxReadTxns.
- aw_grant = (state==WRITE) && wr_cnt < MaxWriteTxns.
- Gating when grant = 0: mst ar_valid = 0 and slv ar_ready = 0; the AW channel is gated the same way.
- Counters:
  - rd_cnt increments on an AR handshake and decrements on an R handshake with last = 1.
  - wr_cnt increments on an AW handshake and decrements on a B handshake.
  - Increment and decrement in the same cycle leave the count unchanged.
  - A decrement at 0 holds 0 and fires an assertion.
- budget counts address handshakes in the current phase and is cleared on every phase entry.
- last_dir register holds the most recently served direction; reset value WRITE, so reads win the first tie.
- FSM transitions, evaluated on registered state with slv_req_i valids:
  - IDLE: if ar_valid && aw_valid, go to READ when last_dir==WRITE, otherwise WRITE. If only one valid, go to that direction. Entry from IDLE is direct, without TURN.
  - READ:
    - At an AR handshake that brings budget to PhaseBudget, or in any cycle with no ar_valid: if aw_valid, go to TURN targeting WRITE.
    - Otherwise, if ar_valid is low, go to IDLE.
    - Otherwise (budget reached, ar_valid high, no aw_valid), clear budget and stay in READ.
  - WRITE: symmetric to READ.
  - TURN: tc counts 0..TurnCycles-1 with both grants low, then enters the target. With TurnCycles = 0, READ and WRITE switch directly without entering TURN.
  - Entering READ or WRITE sets last_dir.
- Outstanding limit reached: the phase stays active and stalls. If the other direction is waiting, the stall counts as "no grant possible". The phase yields after the current handshake or immediately if none is in progress.
- Yielding does not wait for outstanding responses to drain.

## Timing
- Zero-latency pass-through: grants are a combinational function of registered state and counters, and ready/valid are ANDed.
- An address valid on its own is never combinationally dependent on its own ready.
- A state change is effective in the cycle after the deciding edge. The first grant in a new phase is one cycle after entry from IDLE, or TurnCycles+1 cycles after the last handshake of the previous phase.
- A stalled valid at slv is held by the upstream; AXI stability is not violated because mst valid is masked, never retracted after mst handshake.
- Reset values: state IDLE, phase_o 0, rd/wr counts 0, budget 0, tc 0, last_dir WRITE. mst_req_o aw/ar_valid are 0 during reset; other outputs mirror the inputs.
- Reset asserted mid-phase or mid-burst clears all state immediately, with no drain.

## Test plan
- Reads only, 10 back-to-back ARs, MaxReadTxns = 8, HBM responds after 20 cycles -> 8 ARs granted, rd_outstanding_o = 8, the 9th is stalled until R last returns; phase_o stays 1; no TURN.
- Simultaneous AR and AW streams, PhaseBudget = 4, TurnCycles = 2 -> the first 4 ARs are granted, then 2 cycles with phase_o = 3 and no address handshake, then 4 AWs, alternating.
- AW and AR arrive in the same cycle from IDLE after reset -> READ is entered first; after an intervening write phase, the next IDLE tie picks the direction opposite last_dir.
- TurnCycles = 0 with alternating single AR and single AW -> phase_o is never 3; each switch costs exactly one cycle.
- R last and AR handshake in the same cycle at rd_cnt = 5 -> rd_cnt stays 5; B at wr_cnt = 0 -> count stays 0 and the assertion fires.
- Reset asserted while wr_cnt = 3 in WRITE -> all counts 0, phase_o = 0, mst aw/ar valid low during reset; after release, a fresh write is granted within 2 cycles.

Source files
------------

// File: rtl/floo_hbm_rw_scheduler.sv
// Read/write phase scheduler for the joined AXI bus in front of an HBM channel.
// It groups AR and AW grants into bounded phases, inserts a turnaround gap
// between phases and caps outstanding reads and writes. It adds no register
// stage: gating is combinational on registered state.

package floo_hbm_rw_scheduler_pkg;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ax_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    r_chan_t r;
    logic    r_valid;
  } axi_rsp_t;

endpackage

module floo_hbm_rw_scheduler #(
  parameter int  MaxReadTxns  = 8,
  parameter int  MaxWriteTxns = 8,
  parameter int  PhaseBudget  = 4,
  parameter int  TurnCycles   = 2,
  parameter type axi_req_t    = floo_hbm_rw_scheduler_pkg::axi_req_t,
  parameter type axi_rsp_t    = floo_hbm_rw_scheduler_pkg::axi_rsp_t,
  localparam int RdW          = $clog2(MaxReadTxns + 1),
  localparam int WrW          = $clog2(MaxWriteTxns + 1)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  axi_req_t       slv_req_i,
  output axi_rsp_t       slv_rsp_o,
  output axi_req_t       mst_req_o,
  input  axi_rsp_t       mst_rsp_i,
  output logic [1:0]     phase_o,
  output logic [RdW-1:0] rd_outstanding_o,
  output logic [WrW-1:0] wr_outstanding_o
);

  localparam int BudW = (PhaseBudget > 1) ? $clog2(PhaseBudget) : 1;
  localparam int TcW  = (TurnCycles > 1) ? $clog2(TurnCycles) : 1;

  localparam logic [RdW-1:0]  RdMax   = RdW'(MaxReadTxns);
  localparam logic [WrW-1:0]  WrMax   = WrW'(MaxWriteTxns);
  localparam logic [BudW-1:0] BudLast = BudW'(PhaseBudget - 1);
  localparam logic [TcW-1:0]  TcLast  = TcW'(TurnCycles - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    TURN  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  state_e          target_q, target_d;
  state_e          last_dir_q, last_dir_d;
  logic [BudW-1:0] budget_q, budget_d;
  logic [TcW-1:0]  tc_q, tc_d;
  logic [RdW-1:0]  rd_cnt_q, rd_cnt_d;
  logic [WrW-1:0]  wr_cnt_q, wr_cnt_d;

  logic ar_v, aw_v;
  logic ar_grant, aw_grant;
  logic ar_hs, aw_hs, r_last_hs, b_hs;
  logic rd_hit, wr_hit, rd_yield, wr_yield;

  // Grants depend only on registered state, so no valid ever loops back through its own ready.
  assign ar_v     = slv_req_i.ar_valid;
  assign aw_v     = slv_req_i.aw_valid;
  assign ar_grant = (state_q == READ)  && (rd_cnt_q < RdMax);
  assign aw_grant = (state_q == WRITE) && (wr_cnt_q < WrMax);

  assign ar_hs     = ar_v && ar_grant && mst_rsp_i.ar_ready;
  assign aw_hs     = aw_v && aw_grant && mst_rsp_i.aw_ready;
  assign r_last_hs = mst_rsp_i.r_valid && slv_req_i.r_ready && mst_rsp_i.r.last;
  assign b_hs      = mst_rsp_i.b_valid && slv_req_i.b_ready;

  // A phase is over when its budget is spent, its requester goes quiet or its limit stalls it.
  assign rd_hit   = ar_hs && (budget_q == BudLast);
  assign wr_hit   = aw_hs && (budget_q == BudLast);
  assign rd_yield = rd_hit || !ar_v || !ar_grant;
  assign wr_yield = wr_hit || !aw_v || !aw_grant;

  // Pass everything through, masking only the address valid/ready pairs.
  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.ar_valid = slv_req_i.ar_valid & ar_grant;
    mst_req_o.aw_valid = slv_req_i.aw_valid & aw_grant;
    slv_rsp_o          = mst_rsp_i;
    slv_rsp_o.ar_ready = mst_rsp_i.ar_ready & ar_grant;
    slv_rsp_o.aw_ready = mst_rsp_i.aw_ready & aw_grant;
  end

  // Next-state logic for phase, turnaround target, budget and tie-break direction.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d    = state_q;
    target_d   = target_q;
    last_dir_d = last_dir_q;
    budget_d   = budget_q;
    tc_d       = tc_q;
    case (state_q)
      IDLE: begin
        if (ar_v && aw_v) state_d = (last_dir_q == WRITE) ? READ : WRITE;
        else if (ar_v)    state_d = READ;
        else if (aw_v)    state_d = WRITE;
      end
      READ: begin
        if (rd_yield && aw_v) begin
          state_d  = (TurnCycles == 0) ? WRITE : TURN;
          target_d = WRITE;
        end else if (!ar_v) begin
          state_d = IDLE;
        end else if (rd_hit) begin
          budget_d = '0;
        end else if (ar_hs) begin
          budget_d = budget_q + BudW'(1);
        end
      end
      WRITE: begin
        if (wr_yield && ar_v) begin
          state_d  = (TurnCycles == 0) ? READ : TURN;
          target_d = READ;
        end else if (!aw_v) begin
          state_d = IDLE;
        end else if (wr_hit) begin
          budget_d = '0;
        end else if (aw_hs) begin
          budget_d = budget_q + BudW'(1);
        end
      end
      TURN: begin
        if (tc_q == TcLast) begin
          state_d = target_q;
          tc_d    = '0;
        end else begin
          tc_d = tc_q + TcW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) budget_d = '0;
    if (state_d != state_q && (state_d == READ || state_d == WRITE)) last_dir_d = state_d;
  end

  // Outstanding counters: simultaneous up and down cancel, a stray decrement at zero holds.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (ar_hs && !r_last_hs)                            rd_cnt_d = rd_cnt_q + RdW'(1);
    else if (!ar_hs && r_last_hs && rd_cnt_q != '0)     rd_cnt_d = rd_cnt_q - RdW'(1);
    if (aw_hs && !b_hs)                                 wr_cnt_d = wr_cnt_q + WrW'(1);
    else if (!aw_hs && b_hs && wr_cnt_q != '0)          wr_cnt_d = wr_cnt_q - WrW'(1);
  end

  // State registers; reset drops everything at once without draining.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      target_q   <= READ;
      last_dir_q <= WRITE;
      budget_q   <= '0;
      tc_q       <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q    <= state_d;
      target_q   <= target_d;
      last_dir_q <= last_dir_d;
      budget_q   <= budget_d;
      tc_q       <= tc_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  assign phase_o          = state_q;
  assign rd_outstanding_o = rd_cnt_q;
  assign wr_outstanding_o = wr_cnt_q;

  // A response with nothing outstanding means the downstream broke the protocol.
  rd_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(r_last_hs && !ar_hs && rd_cnt_q == '0))
    else $error("read counter decrement at zero");

  wr_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(b_hs && !aw_hs && wr_cnt_q == '0))
    else $error("write counter decrement at zero");

endmodule
